alu_pkt_sched: RTL
==================

# alu_pkt_sched

Packet scheduler between the UART byte streams and the shared 32-bit ALU. It parses framed command packets from the receiver and, for arithmetic commands, folds the operand words through the ALU one operation at a time. It returns the 32-bit result to the transmitter, or echoes payload bytes for the echo command. It sits inside the UART-ALU wrapper, after the receiver and before the transmitter.

## Interface
- `MaxLen`, default 16'hFFFF: largest accepted packet length in bytes, header included; a larger `len` is malformed.
- `clk_i` in 1: system clock (18 MHz on the iCESugar build).
- `reset_ni` in 1: asynchronous, active-low reset.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: received byte valid.
- `rx_ready_o` out 1: byte accepted when `rx_valid_i & rx_ready_o`.
- `tx_data_o` out 8: byte to transmit.
- `tx_valid_o` out 1: transmit byte valid.
- `tx_ready_i` in 1: transmitter accepts the byte on `tx_valid_o & tx_ready_i`.
- `alu_op_o` out 2: ALU operation; 0 = add, 1 = mul, 2 = div.
- `alu_a_o` out 32: accumulator operand.
- `alu_b_o` out 32: new operand.
- `alu_valid_o` out 1: ALU request.
- `alu_ready_i` in 1: ALU takes the request on `alu_valid_o & alu_ready_i`.
- `alu_res_valid_i` in 1: one-cycle result strobe.
- `alu_res_i` in 32: ALU result.
- `err_o` out 1: one-cycle pulse when a packet is dropped.

## Operation
- Packet format: opcode, reserved, `len[7:0]`, `len[15:8]`, then payload.
- `len` is the total packet byte count including the 4-byte header, little-endian.
- Opcodes: 0xEC = echo, 0xA0 = add, 0xA1 = mul, 0xA2 = div (unsigned).
- A 16-bit byte counter counts every accepted byte of the packet. The packet ends when the counter equals `len`.
- States:
  - IDLE/HDR: receive 4 header bytes; `rx_ready_o` = 1.
  - ECHO: combinational pass-through. `tx_data_o` = `rx_data_i`, `tx_valid_o` = `rx_valid_i`, `rx_ready_o` = `tx_ready_i`. Leave for HDR when the byte counter reaches `len`.
  - LOADA: shift in 4 bytes, LSB first, into the accumulator.
  - LOADB: shift in 4 bytes into `alu_b_o`; then go to ISSUE.
  - ISSUE: hold `alu_valid_o` until `alu_ready_i`; then go to WAIT.
  - WAIT: on `alu_res_valid_i`, write the result to the accumulator. If bytes remain, go to LOADB; otherwise go to SEND.
  - SEND: transmit the 4 accumulator bytes LSB first, one per `tx_valid_o & tx_ready_i`; then go to HDR.
  - DRAIN: `rx_ready_o` = 1, discard bytes until the counter reaches `len`; then go to HDR.
- Malformed packets:
  - Unknown opcode with `len` > 4: pulse `err_o` at header end, then DRAIN.
  - Arithmetic opcode where `len - 4` is not a multiple of 4, is less than 8, or `len` > `MaxLen`: pulse `err_o`, then DRAIN.
  - `len` < 4: the packet ends after the header. Pulse `err_o` only for a non-echo opcode; send no response.
  - Echo with `len` = 4: no output, return to HDR.
- Division by zero is forwarded to the ALU unchanged. The ALU's result is returned as-is.
- `rx_ready_o` = 0 in ISSUE, WAIT and SEND; `tx_valid_o` = 0 outside ECHO and SEND.

## Timing
- Reset values: state HDR, counter 0, accumulator 0, `rx_ready_o` = 1, `tx_valid_o` = 0, `tx_data_o` = 0, `alu_valid_o` = 0, `alu_op_o` = 0, `alu_a_o` = 0, `alu_b_o` = 0, `err_o` = 0.
- Assertion of `reset_ni` mid-packet or mid-ALU returns all state to reset values immediately. Stale `alu_res_valid_i` pulses are ignored while in HDR.
- Header decode is registered:
  - The first payload byte can be accepted the cycle after the 4th header byte.
  - `err_o` pulses in the cycle after the 4th header byte.
- `alu_op_o`, `alu_a_o` and `alu_b_o` are stable from ISSUE entry until the result strobe.
- Only one ALU request is outstanding at a time.
- The first SEND byte is valid the cycle after the final `alu_res_valid_i`.
- `tx_data_o` and `tx_valid_o` hold until accepted; backpressure of any length is tolerated.
- In ECHO there is zero latency, and `rx_valid_i` with `tx_ready_i` = 0 stalls the receiver.
- The byte counter is 16-bit and never wraps, because `len` ≤ 0xFFFF.
- If the ALU answers in the same cycle as the request (`alu_ready_i` and `alu_res_valid_i` together in ISSUE), the result is taken that cycle.

## Test plan
- Add packet A0 00 10 00, words 1, 2, 3 (LE) -> ALU sees add(1,2) then add(3,3); TX 06 00 00 00.
- Mul packet A1 00 0C 00, words 0x00010000 and 0x00010000 -> TX 00 00 00 00 (wrap). Then hold `tx_ready_i` low 50 cycles -> byte 0 holds, no loss.
- Echo EC 00 07 00 41 42 43 -> TX 41 42 43; next header accepted immediately.
- Unknown opcode 55 00 08 00 plus 4 bytes -> one `err_o` pulse, no TX, bytes drained. A following add packet returns its correct result.
- Add packet with `len` = 0x000A -> `err_o`, 6 bytes drained, no ALU request.
- Assert `reset_ni` during WAIT of a div packet, then release and send a div packet of 100 and 7 -> reset values observed; TX 0E 00 00 00.

Source files
------------

// File: rtl/alu_pkt_sched.sv
// alu_pkt_sched: packet scheduler between the UART byte streams and the shared
// 32-bit ALU. Parses framed command packets, folds operand words through the
// ALU one request at a time and returns the 32-bit result, or echoes payload
// bytes straight through for the echo command.
//
// Packet: opcode, reserved, len[7:0], len[15:8], payload. len counts the whole
// packet including the 4-byte header.
//
// Ports
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   rx_data_i/valid_i/ready_o   byte stream from the receiver
//   tx_data_o/valid_o/ready_i   byte stream to the transmitter
//   alu_op_o/a_o/b_o/valid_o, alu_ready_i   ALU request channel
//   alu_res_valid_i, alu_res_i              ALU result strobe
//   err_o                   one-cycle pulse when a packet is dropped
//
// rx_ready_o, tx_valid_o and tx_data_o are decoded from registered state; in
// ECHO they pass the byte streams through combinationally for zero latency.

module alu_pkt_sched #(
  parameter int unsigned MaxLen = 32'h0000_FFFF
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic        alu_res_valid_i,
  input  logic [31:0] alu_res_i,
  output logic        err_o
);

  localparam int unsigned ByteW       = 8;
  localparam int unsigned WordW       = 32;
  localparam int unsigned CntW        = 16;
  localparam int unsigned HdrBytes    = 4;
  localparam int unsigned MinArithPay = 8;

  localparam logic [ByteW-1:0] OpEcho = 8'hEC;
  localparam logic [ByteW-1:0] OpAdd  = 8'hA0;
  localparam logic [ByteW-1:0] OpMul  = 8'hA1;
  localparam logic [ByteW-1:0] OpDiv  = 8'hA2;

  typedef enum logic [2:0] {
    S_HDR,
    S_ECHO,
    S_LOADA,
    S_LOADB,
    S_ISSUE,
    S_WAIT,
    S_SEND,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  state_e            hdr_state;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_inc;
  logic [CntW-1:0]   len_q;
  logic [CntW-1:0]   hdr_len;
  logic [CntW-1:0]   pay_len;
  logic [ByteW-1:0]  opcode_q;
  logic [ByteW-1:0]  len_lo_q;
  logic [WordW-1:0]  acc_q;
  logic [WordW-1:0]  b_q;
  logic [1:0]        op_q;
  logic [1:0]        hdr_op;
  logic [1:0]        send_idx_q;
  logic              alu_valid_q;
  logic              err_q;
  logic              hdr_err;
  logic              len_long;
  logic              rx_fire;
  logic              tx_fire;
  logic              alu_fire;
  logic              hdr_last;
  logic              ops_done;
  logic              res_take;
  logic              pkt_end;
  logic              issue_enter;

  assign alu_op_o    = op_q;
  assign alu_a_o     = acc_q;
  assign alu_b_o     = b_q;
  assign alu_valid_o = alu_valid_q;
  assign err_o       = err_q;

  // Handshakes and packet bookkeeping.
  assign rx_fire     = rx_valid_i & rx_ready_o;
  assign tx_fire     = tx_valid_o & tx_ready_i;
  assign alu_fire    = alu_valid_q & alu_ready_i;
  assign cnt_inc     = cnt_q + CntW'(1);
  assign hdr_last    = (state_q == S_HDR) & rx_fire & (cnt_q[1:0] == 2'd3);
  assign ops_done    = (cnt_q == len_q);
  assign res_take    = alu_res_valid_i &
                       ((state_q == S_WAIT) | ((state_q == S_ISSUE) & alu_fire));
  assign pkt_end     = (state_d == S_HDR) & ((state_q != S_HDR) | hdr_last);
  assign issue_enter = (state_d == S_ISSUE) & (state_q != S_ISSUE);

  // Header decode: evaluated while the last header byte (len high) is on the bus.
  always_comb begin
    hdr_len   = {rx_data_i, len_lo_q};
    pay_len   = hdr_len - CntW'(HdrBytes);
    len_long  = (hdr_len > CntW'(HdrBytes));
    hdr_state = S_HDR;
    hdr_err   = 1'b0;
    // Arithmetic opcodes A0/A1/A2 map onto ALU ops 0/1/2 by their low bits.
    hdr_op    = opcode_q[1:0];
    case (opcode_q)
      OpEcho: hdr_state = len_long ? S_ECHO : S_HDR;
      OpAdd, OpMul, OpDiv: begin
        if ((hdr_len < CntW'(HdrBytes)) || (WordW'(hdr_len) > MaxLen) ||
            (pay_len[1:0] != 2'd0) || (pay_len < CntW'(MinArithPay))) begin
          hdr_err   = 1'b1;
          hdr_state = len_long ? S_DRAIN : S_HDR;
        end else begin
          hdr_state = S_LOADA;
        end
      end
      default: begin
        hdr_err   = 1'b1;
        hdr_state = len_long ? S_DRAIN : S_HDR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HDR:   if (hdr_last) state_d = hdr_state;
      S_ECHO,
      S_DRAIN: if (rx_fire && (cnt_inc == len_q)) state_d = S_HDR;
      S_LOADA: if (rx_fire && (cnt_q[1:0] == 2'd3)) state_d = S_LOADB;
      S_LOADB: if (rx_fire && (cnt_q[1:0] == 2'd3)) state_d = S_ISSUE;
      S_ISSUE: begin
        // A same-cycle result skips WAIT entirely.
        if (alu_fire) begin
          if (alu_res_valid_i) state_d = ops_done ? S_SEND : S_LOADB;
          else                 state_d = S_WAIT;
        end
      end
      S_WAIT:  if (alu_res_valid_i) state_d = ops_done ? S_SEND : S_LOADB;
      S_SEND:  if (tx_fire && (send_idx_q == 2'd3)) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  // Stream outputs decoded from state.
  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    case (state_q)
      S_HDR, S_LOADA, S_LOADB, S_DRAIN: rx_ready_o = 1'b1;
      S_ECHO: begin
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = acc_q[{send_idx_q, 3'b000} +: ByteW];
      end
      default: ;
    endcase
  end

  // Datapath: header capture, operand shift-in, accumulator, ALU request, error.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q       <= '0;
      len_q       <= '0;
      opcode_q    <= '0;
      len_lo_q    <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      op_q        <= '0;
      send_idx_q  <= '0;
      alu_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= hdr_last & hdr_err;

      if (pkt_end)      cnt_q <= '0;
      else if (rx_fire) cnt_q <= cnt_inc;

      if ((state_q == S_HDR) && rx_fire) begin
        case (cnt_q[1:0])
          2'd0:    opcode_q <= rx_data_i;
          2'd2:    len_lo_q <= rx_data_i;
          2'd3:    len_q    <= hdr_len;
          default: ;
        endcase
      end

      if (hdr_last && (hdr_state == S_LOADA)) op_q <= hdr_op;

      // Operand words arrive LSB first: shift each byte in from the top.
      if ((state_q == S_LOADA) && rx_fire) acc_q <= {rx_data_i, acc_q[WordW-1:ByteW]};
      else if (res_take)                   acc_q <= alu_res_i;

      if ((state_q == S_LOADB) && rx_fire) b_q <= {rx_data_i, b_q[WordW-1:ByteW]};

      if (issue_enter)   alu_valid_q <= 1'b1;
      else if (alu_fire) alu_valid_q <= 1'b0;

      // Wraps back to 0 after the fourth byte, ready for the next response.
      if ((state_q == S_SEND) && tx_fire) send_idx_q <= send_idx_q + 2'd1;
    end
  end

endmodule
